// File: rtl/pipe_reg_skid_if.sv
// pipe_reg_skid_if
//   Handshake bundle for one elastic pipeline stage.
//   Upstream side : in_valid, in_ready, in_data
//   Downstream side: out_valid, out_ready, out_data
//   Status        : level (number of held entries, 0..2)
//   Modports:
//     slave  - the stage itself (consumes in_*, out_ready; drives the rest)
//     master - the environment around the stage (upstream + downstream)
interface pipe_reg_skid_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output level
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  level
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid
//   Two-entry elastic pipeline register (main + skid) with valid/ready
//   handshake. in_ready and out_data come straight from flops, so there is
//   no combinational path from out_ready to in_ready nor from in_* to out_*.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous reset, active low
//     flush - synchronous discard of all held entries (data regs hold)
//     bus   - pipe_reg_skid_if.slave handshake bundle (see interface file)
//
//   state | meaning
//   EMPTY | nothing held; in_ready = 1
//   ONE   | main entry valid, skid empty; in_ready = 1
//   TWO   | main and skid valid; in_ready = 0
module pipe_reg_skid #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  pipe_reg_skid_if.slave bus
);

  // Encoding lets the valid bits fall straight out of the state register:
  // bit 0 = main_valid, bit 1 = skid_valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_ready_q;

  logic             main_valid;
  logic             skid_valid;
  logic             accept;
  logic             pop;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign accept     = bus.in_valid && in_ready_q;
  assign pop        = main_valid && bus.out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush) begin
      // Anything offered or popped this cycle is simply forgotten; data
      // registers keep their contents.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = TWO;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so accept cannot happen.
          if (pop) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: begin
          // Skid-without-main is unreachable; recover to a clean empty stage.
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      // Registered copy of "next state is not TWO" so in_ready is a flop
      // output rather than a decode of the state vector.
      in_ready_q <= (state_nxt != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_data <= RESET_VALUE;
      skid_data <= RESET_VALUE;
    end else begin
      if (load_main) begin
        main_data <= main_from_skid ? skid_data : bus.in_data;
      end
      if (load_skid) begin
        skid_data <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.level     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_reg_skid.sv
module tb_pipe_reg_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, flush_a, flush_b;

  pipe_reg_skid_if #(.WIDTH(32)) ifa ();
  pipe_reg_skid_if #(.WIDTH(8))  ifb ();

  pipe_reg_skid #(.WIDTH(32), .RESET_VALUE(32'h0)) dut_a (
    .clk(clk), .rst(rst_a), .flush(flush_a), .bus(ifa.slave)
  );
  pipe_reg_skid #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b), .bus(ifb.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all DUT A outputs at once.
  task automatic chk_a(input string tag, input logic ir, input logic ov,
                       input logic [31:0] od, input logic [1:0] lv, input logic check_data);
    chk({tag, ".in_ready"},  {31'b0, ifa.in_ready},  {31'b0, ir});
    chk({tag, ".out_valid"}, {31'b0, ifa.out_valid}, {31'b0, ov});
    chk({tag, ".level"},     {30'b0, ifa.level},     {30'b0, lv});
    if (check_data) chk({tag, ".out_data"}, ifa.out_data, od);
  endtask

  // Reference model for the soak: a bounded FIFO of at most two entries.
  logic [7:0] q[$];
  bit         just_reset;
  bit         iv, ordy, fl, rb;
  logic [7:0] din;

  initial begin
    rst_a = 1'b0; flush_a = 1'b0;
    rst_b = 1'b0; flush_b = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 32'hDEADBEEF; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00;        ifb.out_ready = 1'b0;

    // Reset and idle: offered data must not be accepted.
    tick(); chk_a("rst0", 1, 0, 32'h0, 0, 1);
    tick(); chk_a("rst1", 1, 0, 32'h0, 0, 1);
    rst_a = 1'b1; ifa.in_valid = 1'b0;
    tick(); chk_a("idle", 1, 0, 32'h0, 0, 1);

    // Streaming at full rate.
    ifa.out_ready = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_data = 32'h1; tick(); chk_a("str1", 1, 1, 32'h1, 1, 1);
    ifa.in_data = 32'h2;                      tick(); chk_a("str2", 1, 1, 32'h2, 1, 1);
    ifa.in_data = 32'h3;                      tick(); chk_a("str3", 1, 1, 32'h3, 1, 1);
    ifa.in_valid = 1'b0;                      tick(); chk_a("str_end", 1, 0, 32'h0, 0, 0);

    // Backpressure and skid.
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 32'hA; tick(); chk_a("bp_a", 1, 1, 32'hA, 1, 1);
    ifa.in_data = 32'hB;                      tick(); chk_a("bp_b", 0, 1, 32'hA, 2, 1);
    ifa.in_valid = 1'b0;                      tick(); chk_a("bp_hold", 0, 1, 32'hA, 2, 1);
    ifa.out_ready = 1'b1;                     tick(); chk_a("bp_popa", 1, 1, 32'hB, 1, 1);
                                              tick(); chk_a("bp_popb", 1, 0, 32'h0, 0, 0);

    // Simultaneous accept and pop in ONE.
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 32'h5; tick(); chk_a("sim5", 1, 1, 32'h5, 1, 1);
    ifa.in_data = 32'h6; ifa.out_ready = 1'b1; tick(); chk_a("sim6", 1, 1, 32'h6, 1, 1);
    ifa.in_valid = 1'b0;                      tick(); chk_a("sim_end", 1, 0, 32'h0, 0, 0);

    // Flush in TWO with an input offered.
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 32'hC; tick();
    ifa.in_data = 32'hD;                      tick(); chk_a("fl_two", 0, 1, 32'hC, 2, 1);
    ifa.in_data = 32'hE; flush_a = 1'b1;      tick(); chk_a("fl_two_post", 1, 0, 32'h0, 0, 0);
    flush_a = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    tick(); chk_a("fl_no_e", 1, 0, 32'h0, 0, 0);

    // Flush in ONE while in_ready is high: offered word is dropped.
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 32'h7; tick(); chk_a("fl_one", 1, 1, 32'h7, 1, 1);
    ifa.in_data = 32'h8; flush_a = 1'b1;      tick(); chk_a("fl_one_post", 1, 0, 32'h0, 0, 0);
    flush_a = 1'b0; ifa.in_valid = 1'b0;
    tick(); chk_a("fl_one_drop", 1, 0, 32'h0, 0, 0);

    // Reset mid-operation from TWO.
    ifa.in_valid = 1'b1; ifa.in_data = 32'hF0; tick();
    ifa.in_data = 32'hF1;                      tick(); chk_a("mid_two", 0, 1, 32'hF0, 2, 1);
    rst_a = 1'b0;                              tick(); chk_a("mid_rst", 1, 0, 32'h0, 0, 1);
    rst_a = 1'b1; ifa.in_valid = 1'b0;

    // Random soak on the 8-bit instance.
    tick(); tick();
    chk("soak_rst_data", {24'b0, ifb.out_data}, 32'h5A);
    rst_b = 1'b1;
    q.delete();
    just_reset = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("soak.level",     {30'b0, ifb.level},     q.size());
      chk("soak.level_max", {31'b0, (ifb.level <= 2'd2)}, 32'd1);
      chk("soak.in_ready",  {31'b0, ifb.in_ready},  {31'b0, (q.size() < 2)});
      chk("soak.out_valid", {31'b0, ifb.out_valid}, {31'b0, (q.size() > 0)});
      // Head compare also covers stability under stall: the model head only
      // changes on pop, flush or reset.
      if (q.size() > 0) chk("soak.out_data", {24'b0, ifb.out_data}, {24'b0, q[0]});
      if (just_reset)   chk("soak.post_rst", {24'b0, ifb.out_data}, 32'h5A);

      rb   = ($urandom_range(0, 999) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      din  = 8'($urandom_range(0, 255));
      rst_b = rb; flush_b = fl;
      ifb.in_valid = iv; ifb.in_data = din; ifb.out_ready = ordy;

      if (!rb) begin
        q.delete();
        just_reset = 1'b1;
      end else begin
        just_reset = 1'b0;
        if (fl) begin
          q.delete();
        end else begin
          bit acc, pp;
          acc = iv && (q.size() < 2);
          pp  = ordy && (q.size() > 0);
          if (pp)  void'(q.pop_front());
          if (acc) q.push_back(din);
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
